// File: rtl/beta_pkg.sv
// Shared definitions for the serial digit-wise subtractor.
//
// Contents:
//   DEF_WIDTH / DEF_DIGIT : default operand width and digit width in bits
//   ST_IDLE / ST_RUN / ST_DONE : FSM state encoding
//   cnt_width()           : width of the digit counter for a given digit count
package beta_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // clog2 of the digit count, kept at least one bit wide so a
    // single-digit configuration still has a legal counter vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_sub_beta.sv
// One digit of the serial subtractor: a - b - borrow_in.
//
// Ports:
//   a          : minuend digit
//   b          : subtrahend digit
//   borrow_in  : borrow from the next-lower digit
//   diff       : digit of the difference
//   borrow_out : borrow into the next-higher digit
module digit_sub_beta #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             borrow_in,
    output logic [DIGIT-1:0] diff,
    output logic             borrow_out
);

    // One bit wider than the digit: the extra top bit goes to one exactly
    // when the subtraction underflows, which is the outgoing borrow.
    logic [DIGIT:0] wide;

    assign wide       = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, borrow_in};
    assign diff       = wide[DIGIT-1:0];
    assign borrow_out = wide[DIGIT];

endmodule

// File: rtl/sub_beta_serial.sv
// Serial subtractor: out_diff = in_sum - in_addend (mod 2^WIDTH), processed
// DIGIT bits per cycle, least significant digit first.
//
// Ports:
//   clock      : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   in_valid   : operand pair valid       in_ready  : block idle, accepts operands
//   in_sum     : minuend                  in_addend : subtrahend
//   out_valid  : result valid (DONE)      out_ready : consumer accepts result
//   out_diff   : difference (partial while running, qualify with out_valid)
//   out_borrow : set when in_sum < in_addend (unsigned)
//
// Timing: operands accepted at edge T, out_valid high from edge T+N where
// N = WIDTH/DIGIT; the result is held until out_ready, then back to IDLE.
module sub_beta_serial
    import beta_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_addend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] addend_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             borrow_reg;
    logic             out_borrow_reg;

    logic [DIGIT-1:0] slice_diff;
    logic             slice_borrow;

    // The captured operands are shifted right one digit per RUN cycle, so the
    // digit being worked on always sits in the low DIGIT bits.
    digit_sub_beta #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a          (sum_reg[DIGIT-1:0]),
        .b          (addend_reg[DIGIT-1:0]),
        .borrow_in  (borrow_reg),
        .diff       (slice_diff),
        .borrow_out (slice_borrow)
    );

    // The difference is assembled in place: only the digit selected by the
    // counter is replaced, so out_diff shows the low digits finished so far.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_diff_slice
            assign diff_next[gi*DIGIT +: DIGIT] =
                (state_reg == ST_RUN && cnt_reg == CNT_W'(gi))
                    ? slice_diff
                    : diff_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            sum_reg        <= '0;
            addend_reg     <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            borrow_reg     <= 1'b0;
            out_borrow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum_reg        <= in_sum;
                        addend_reg     <= in_addend;
                        diff_reg       <= '0;
                        cnt_reg        <= '0;
                        borrow_reg     <= 1'b0;
                        out_borrow_reg <= 1'b0;
                        state_reg      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    diff_reg   <= diff_next;
                    sum_reg    <= sum_reg >> DIGIT;
                    addend_reg <= addend_reg >> DIGIT;
                    borrow_reg <= slice_borrow;
                    if (cnt_reg == LAST_DIGIT) begin
                        // Borrow out of the top digit is the unsigned
                        // "sum < addend" flag.
                        out_borrow_reg <= slice_borrow;
                        cnt_reg        <= '0;
                        state_reg      <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so an
    // asynchronous reset updates them without waiting for a clock edge.
    assign in_ready   = (state_reg == ST_IDLE);
    assign out_valid  = (state_reg == ST_DONE);
    assign out_diff   = diff_reg;
    assign out_borrow = out_borrow_reg;

endmodule

// File: tb/tb_sub_beta_serial.sv
module tb_sub_beta_serial;

    localparam int WIDTH = 32;
    localparam int N     = 8;

    logic             clock;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_addend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;

    int tests_run;
    int tests_failed;

    sub_beta_serial #(
        .WIDTH (WIDTH),
        .DIGIT (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_addend  (in_addend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain unsigned arithmetic on the whole word.
    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] a);
        return s - a;
    endfunction

    function automatic logic ref_borrow(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] a);
        return (s < a);
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operand pair, wait (bounded) for the result, capture it, then
    // hand it off. lat counts edges from the accept edge to out_valid.
    task automatic run_op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] a,
                          output logic [WIDTH-1:0] d, output logic b, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_sum    = s;
        in_addend = a;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        // Scramble inputs after capture; the result must not depend on them.
        in_sum    = $urandom;
        in_addend = $urandom;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        d = out_diff;
        b = out_borrow;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        $display("[TB] op sum=%08h addend=%08h -> diff=%08h borrow=%0b lat=%0d", s, a, d, b, lat);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sum    = '0;
        in_addend = '0;
        repeat (3) tick();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_diff !== '0 || out_borrow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_diff=%08h out_borrow=%0b, required 1 0 00000000 0",
                     in_ready, out_valid, out_diff, out_borrow);
        end
        reset_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] d;
        logic b;
        int lat;
        run_op(32'h0000_0019, 32'h0000_000A, d, b, lat);
        tests_run++;
        if (d !== 32'h0000_000F || b !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: diff=%08h borrow=%0b, required 0000000f 0", d, b);
        end
        tests_run++;
        if (lat !== N) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", lat, N);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d;
        logic b;
        int lat;
        run_op(32'h0000_0000, 32'h0000_0001, d, b, lat);
        tests_run++;
        if (d !== 32'hFFFF_FFFF || b !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_result: diff=%08h borrow=%0b, required ffffffff 1", d, b);
        end
    endtask

    task automatic test_cross_borrow();
        logic [WIDTH-1:0] d;
        logic b;
        int lat;
        run_op(32'h1234_5678, 32'h1234_5678, d, b, lat);
        tests_run++;
        if (d !== 32'h0000_0000 || b !== 1'b0) begin
            tests_failed++;
            $display("FAIL equal_operands: diff=%08h borrow=%0b, required 00000000 0", d, b);
        end
        run_op(32'h0000_0100, 32'h0000_0001, d, b, lat);
        tests_run++;
        if (d !== 32'h0000_00FF || b !== 1'b0) begin
            tests_failed++;
            $display("FAIL borrow_chain: diff=%08h borrow=%0b, required 000000ff 0", d, b);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s, a, d;
        logic b;
        int lat;
        for (int i = 0; i < 20; i++) begin
            s = $urandom;
            a = (i % 4 == 0) ? s + WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            run_op(s, a, d, b, lat);
            tests_run++;
            if (d !== ref_diff(s, a) || b !== ref_borrow(s, a) || lat !== N) begin
                tests_failed++;
                $display("FAIL random_op%0d: diff=%08h borrow=%0b lat=%0d, required %08h %0b %0d",
                         i, d, b, lat, ref_diff(s, a), ref_borrow(s, a), N);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] s, a;
        int guard;
        s = $urandom;
        a = $urandom;
        in_sum    = s;
        in_addend = a;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            tick();
            guard++;
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_diff !== ref_diff(s, a) || out_borrow !== ref_borrow(s, a)) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d: out_valid=%0b in_ready=%0b diff=%08h borrow=%0b, required 1 0 %08h %0b",
                         c, out_valid, in_ready, out_diff, out_borrow, ref_diff(s, a), ref_borrow(s, a));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        $display("[TB] backpressure sum=%08h addend=%08h released", s, a);
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] s, a, d;
        logic b;
        int lat;
        in_sum    = $urandom;
        in_addend = $urandom;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        // Still mid-cycle: any change here comes from the asynchronous reset.
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_diff !== '0 || out_borrow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: in_ready=%0b out_valid=%0b diff=%08h borrow=%0b, required 1 0 00000000 0",
                     in_ready, out_valid, out_diff, out_borrow);
        end
        tick();
        reset_n = 1'b1;
        $display("[TB] reset asserted mid-run and released");
        s = $urandom;
        a = $urandom;
        run_op(s, a, d, b, lat);
        tests_run++;
        if (d !== ref_diff(s, a) || b !== ref_borrow(s, a) || lat !== N) begin
            tests_failed++;
            $display("FAIL after_reset_op: diff=%08h borrow=%0b lat=%0d, required %08h %0b %0d",
                     d, b, lat, ref_diff(s, a), ref_borrow(s, a), N);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] q_sum[$];
        logic [WIDTH-1:0] q_add[$];
        logic [WIDTH-1:0] es, ea;
        int last_cap;
        int captures;
        int results;
        int guard;
        last_cap  = -1;
        captures  = 0;
        results   = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (out_valid) begin
                es = q_sum.pop_front();
                ea = q_add.pop_front();
                results++;
                tests_run++;
                if (out_diff !== ref_diff(es, ea) || out_borrow !== ref_borrow(es, ea)) begin
                    tests_failed++;
                    $display("FAIL b2b_result%0d: diff=%08h borrow=%0b, required %08h %0b",
                             results, out_diff, out_borrow, ref_diff(es, ea), ref_borrow(es, ea));
                end
                $display("[TB] b2b result %0d sum=%08h addend=%08h diff=%08h", results, es, ea, out_diff);
            end
            in_sum    = $urandom;
            in_addend = $urandom;
            if (in_ready) begin
                q_sum.push_back(in_sum);
                q_add.push_back(in_addend);
                captures++;
                if (last_cap >= 0) begin
                    tests_run++;
                    if (cyc - last_cap !== N + 2) begin
                        tests_failed++;
                        $display("FAIL b2b_interval: got %0d cycles, required %0d", cyc - last_cap, N + 2);
                    end
                end
                last_cap = cyc;
            end
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (q_sum.size() > 0 && guard < 50) begin
            if (out_valid) begin
                es = q_sum.pop_front();
                ea = q_add.pop_front();
                results++;
                tests_run++;
                if (out_diff !== ref_diff(es, ea) || out_borrow !== ref_borrow(es, ea)) begin
                    tests_failed++;
                    $display("FAIL b2b_drain: diff=%08h borrow=%0b, required %08h %0b",
                             out_diff, out_borrow, ref_diff(es, ea), ref_borrow(es, ea));
                end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (results !== captures || captures < 11) begin
            tests_failed++;
            $display("FAIL b2b_count: results=%0d captures=%0d, required equal and at least 11", results, captures);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_cross_borrow();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sub_beta_serial.md
SUB_BETA_SERIAL -- requirements
Module: sub_beta_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair on in_sum/in_addend is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port in_sum  input  WIDTH  minuend, for example a result produced by the adder.
REQ-008 SHALL have port in_addend  input  WIDTH  subtrahend, the known addend to remove.
REQ-009 SHALL have port out_valid  output  1  out_diff/out_borrow hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_diff  output  WIDTH  in_sum - in_addend, modulo 2^WIDTH.
REQ-012 SHALL have port out_borrow  output  1  set when in_sum < in_addend, unsigned.

Function
REQ-013 SHALL implement a three-state FSM:
- IDLE: in_ready=1, out_valid=0.
- RUN: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-014 SHALL, in IDLE with in_valid=1, capture both operands, clear the borrow register and digit counter, and go to RUN on that edge.
REQ-015 SHALL, in RUN, compute one DIGIT-wide slice per cycle, LSB slice first, with borrow-in from the previous slice.
REQ-016 SHALL take exactly N=WIDTH/DIGIT RUN cycles (8 at defaults); the operand is accepted at edge T and out_valid is high from edge T+N.
REQ-017 SHALL go from RUN to DONE on the edge that completes slice N-1, and latch the final borrow into out_borrow.
REQ-018 SHALL hold out_diff, out_borrow and out_valid stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL take a new operand no earlier than the cycle after a DONE handshake (in_ready=1 in IDLE); the minimum issue interval is N+2 cycles.
REQ-020 SHALL ignore in_valid in RUN and DONE, and SHALL ignore out_ready outside DONE.
REQ-021 SHALL ignore changes to in_sum/in_addend after capture.
REQ-022 SHALL drive out_diff with the partial result in RUN; consumers SHALL qualify it with out_valid.
REQ-023 SHALL wrap the difference modulo 2^WIDTH, with no saturation.

Reset
REQ-024 SHALL, on reset_n low, immediately force state IDLE, in_ready=1, out_valid=0, out_diff=0, out_borrow=0, and clear the counter and internal borrow, independent of clock.
REQ-025 SHALL abandon an operation in progress when reset is asserted mid-RUN or in DONE, with no result emitted.
REQ-026 SHALL accept in_valid on the first rising edge after reset_n is deasserted.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/RUN/DONE) and default WIDTH/DIGIT constants in shared package beta_pkg.
REQ-028 SHALL instantiate one sub-module, digit_sub_beta: a combinational DIGIT-bit subtract with borrow_in, producing diff and borrow_out.
REQ-029 SHALL keep the counter width at clog2(WIDTH/DIGIT), with no other sub-modules.

Verification
REQ-030 SHALL check the basic case: sum=0x00000019, addend=0x0000000A -> out_diff=0x0000000F, out_borrow=0, out_valid exactly 8 cycles after accept.
REQ-031 SHALL check wrap-around: sum=0x00000000, addend=0x00000001 -> out_diff=0xFFFFFFFF, out_borrow=1.
REQ-032 SHALL check cross-slice borrow propagation: sum=0x12345678, addend=0x12345678 -> out_diff=0, out_borrow=0; and sum=0x00000100, addend=0x00000001 -> out_diff=0x000000FF.
REQ-033 SHALL check backpressure: out_ready low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; single handshake on release, IDLE next cycle.
REQ-034 SHALL check reset mid-RUN: reset_n low at RUN cycle 4 -> asynchronously in_ready=1 and out_valid=0; the next operand computes correctly.
REQ-035 SHALL check back-to-back issue: in_valid held high with operands changing every cycle -> exactly one capture per IDLE, each result matching the operand captured at its accept edge.
